// File: rtl/nora_slv_master.sv
// rtl/nora_slv_master.sv - NORA slave register bus initiator: one command in, one timed bus access, one response out.
module nora_slv_master #(
    parameter int ACCESS_CYCLES = 4,
    parameter int GAP_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_rwn_i,
    input  logic [4:0] cmd_addr_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_wr_o,
    output logic [4:0] slv_addr_o,
    output logic [7:0] slv_datawr_o,
    output logic       slv_datawr_valid_o,
    output logic       slv_req_o,
    output logic       slv_rwn_o,
    input  logic [7:0] slv_datard_i,
    output logic       busy_o
);
    localparam int AC_C  = (ACCESS_CYCLES < 2) ? 2 : ((ACCESS_CYCLES > 15) ? 15 : ACCESS_CYCLES);
    localparam int GAP_C = (GAP_CYCLES < 0) ? 0 : ((GAP_CYCLES > 7) ? 7 : GAP_CYCLES);
    // Terminal counts: ACCESS lasts AC_C-1 cycles, the strobe cycle follows.
    localparam logic [3:0] ACC_LAST = 4'(AC_C - 2);
    localparam logic [3:0] GAP_LAST = 4'((GAP_C > 0) ? (GAP_C - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_STROBE,
        S_RESP,
        S_GAP
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rwn_q, rwn_d;
    logic [7:0] rdata_q, rdata_d;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : (v + 4'd1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 5'd0;
            wdata_q <= 8'd0;
            rwn_q   <= 1'b1;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rwn_q   <= rwn_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        rwn_d              = rwn_q;
        rdata_d            = rdata_q;
        cmd_ready_o        = 1'b0;
        rsp_valid_o        = 1'b0;
        rsp_wr_o           = 1'b0;
        slv_req_o          = 1'b0;
        slv_datawr_valid_o = 1'b0;
        slv_rwn_o          = 1'b1;
        case (state_q)
            S_IDLE: begin
                // Gated by reset so the handshake reads 0 while reset is held.
                cmd_ready_o = ~reset;
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    rwn_d   = cmd_rwn_i;
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                slv_req_o = 1'b1;
                slv_rwn_o = rwn_q;
                if (cnt_q >= ACC_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_STROBE: begin
                slv_req_o          = 1'b1;
                slv_datawr_valid_o = 1'b1;
                slv_rwn_o          = rwn_q;
                rdata_d            = rwn_q ? slv_datard_i : 8'h00;
                state_d            = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_wr_o    = ~rwn_q;
                if (rsp_ready_i) begin
                    cnt_d   = 4'd0;
                    state_d = (GAP_C == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign slv_addr_o   = addr_q;
    assign slv_datawr_o = wdata_q;
    assign rsp_rdata_o  = rdata_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule
